fwd_hazard_ctrl: RTL and testbench
==================================

Name: fwd_hazard_ctrl

Overview:
- Pipeline scheduler that drives the select inputs of the two EX-stage 3-to-1 operand muxes (ALU source A and ALU source B).
- Generates load-use stall and branch-flush controls for the 5-stage pipelined CPU.
- Keeps its own shadow copy of destination-register/write-enable info for the EX, MEM and WB slots. The datapath only presents ID-stage decode info plus branch resolution.

Parameters:
REG_AW, 5, register-address width (32 GPRs; address 0 is hard-wired zero).
FLUSH_CYCLES, 1, bubbles inserted after a taken branch (legal range 1..3).

Ports:
clk_i  in  1  clock, rising edge.
rst_i  in  1  asynchronous, active-low reset.
id_valid_i  in  1  ID stage holds a real instruction.
id_rs_i  in  REG_AW  rs of ID instruction.
id_rt_i  in  REG_AW  rt of ID instruction.
id_uses_rt_i  in  1  ID instruction reads rt as a source.
id_rd_i  in  REG_AW  destination register of ID instruction.
id_regwrite_i  in  1  ID instruction writes a register.
id_memread_i  in  1  ID instruction is a load.
branch_taken_i  in  1  branch in EX resolved taken (valid this cycle only).
forward_a_o  out  2  ALU-A mux select: 00 = ID/EX register value, 01 = MEM/WB write-back data, 10 = EX/MEM ALU result.
forward_b_o  out  2  ALU-B mux select, same encoding.
pc_write_o  out  1  PC update enable.
ifid_write_o  out  1  IF/ID register enable.
bubble_o  out  1  zero ID/EX control fields this cycle.
flush_o  out  1  clear IF/ID this cycle.

Behaviour:
- Reset (rst_i low, asynchronous):
  - All shadow slots (EX, MEM, WB) invalid, with regwrite=0 and memread=0.
  - FSM = RUN; flush counter = 0.
  - Outputs: forward_a_o = forward_b_o = 00, pc_write_o = 1, ifid_write_o = 1, bubble_o = 0, flush_o = 0. These hold while reset is asserted.
  - Reset mid-stall or mid-flush aborts the operation with no residual bubble.
- Shadow slots:
  - Each slot holds rs, rt, rd, regwrite, memread.
  - Every edge: WB<=MEM, MEM<=EX.
  - EX <= ID fields when an instruction advances. Otherwise EX <= bubble (regwrite=0, memread=0).
  - Captured regwrite and memread are ANDed with id_valid_i.
- Forwarding (combinational from slots):
  - Forwarding from a slot requires slot regwrite=1 and slot rd != 0.
  - A: 10 if EX/MEM slot qualifies and its rd == EX rs. Else 01 if MEM/WB slot qualifies and its rd == EX rs. Else 00.
  - B: identical, using EX rt.
  - The newer producer (EX/MEM) always wins a double match. Select 11 is never produced.
- FSM states: RUN, STALL, FLUSH.
- RUN:
  - Load-use hazard = EX slot memread & EX rd != 0 & id_valid_i & (EX rd == id_rs_i | (id_uses_rt_i & EX rd == id_rt_i)).
  - On hazard: pc_write_o = 0, ifid_write_o = 0, bubble_o = 1 (all same cycle, combinational). Go to STALL.
  - STALL lasts exactly one cycle, then returns to RUN. The ID instruction is re-evaluated and now forwards via 01.
- Taken branch (branch_taken_i=1 in RUN or STALL):
  - flush_o = 1 and bubble_o = 1 that cycle; the EX capture is a bubble. Counter loads FLUSH_CYCLES-1; enter FLUSH if nonzero, else RUN.
  - Branch has priority over a simultaneous load-use hazard. pc_write_o stays 1 so the target loads.
- FLUSH: flush_o = 1 and bubble_o = 1 while the counter is nonzero; decrement each cycle; RUN at 0. branch_taken_i is ignored while in FLUSH.
- Latency: forwarding and stall decisions are zero-cycle (same-cycle combinational). All state updates occur on the next rising edge.

Test Plan:
- Back-to-back ALU: add r3 then sub r5,r3,r4 -> forward_a_o=10 in sub's EX cycle; forward_b_o=00; no stall.
- Distance-2 dependency: add r3; nop; or r6,r3,r3 -> forward_a_o=01 and forward_b_o=01 in or's EX cycle.
- Double producer: add r2; add r2; and r7,r2,r1 -> forward_a_o=10 (newest wins); writes to r0 never forward (selects stay 00).
- Load-use: lw r4 then add r5,r4,r1 -> exactly one cycle with pc_write_o=0, ifid_write_o=0, bubble_o=1; next cycle forward_a_o=01.
- Branch concurrent with load-use, FLUSH_CYCLES=2 -> flush_o=1 and bubble_o=1 for 2 cycles; no stall cycle; pc_write_o stays 1.
- Assert rst_i low during FLUSH -> outputs return to reset values immediately; after release, RUN with 00 selects.

Source files
------------

// File: rtl/fwd_hazard_ctrl.sv
// EX-stage operand forwarding, load-use stall and taken-branch flush control
// for a 5-stage pipeline. Tracks its own shadow EX/MEM/WB destination info.
module fwd_hazard_ctrl #(
    parameter int unsigned REG_AW       = 5,
    parameter int unsigned FLUSH_CYCLES = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              id_valid_i,
    input  logic [REG_AW-1:0] id_rs_i,
    input  logic [REG_AW-1:0] id_rt_i,
    input  logic              id_uses_rt_i,
    input  logic [REG_AW-1:0] id_rd_i,
    input  logic              id_regwrite_i,
    input  logic              id_memread_i,
    input  logic              branch_taken_i,
    output logic [1:0]        forward_a_o,
    output logic [1:0]        forward_b_o,
    output logic              pc_write_o,
    output logic              ifid_write_o,
    output logic              bubble_o,
    output logic              flush_o
);

    localparam int unsigned CNT_W = 2;
    localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_CYCLES - 1);
    localparam bit FLUSH_MULTI = (FLUSH_CYCLES > 1);

    localparam logic [1:0] SEL_IDEX  = 2'b00;
    localparam logic [1:0] SEL_MEMWB = 2'b01;
    localparam logic [1:0] SEL_EXMEM = 2'b10;

    typedef struct packed {
        logic [REG_AW-1:0] rs;
        logic [REG_AW-1:0] rt;
        logic [REG_AW-1:0] rd;
        logic              regwrite;
        logic              memread;
    } slot_t;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    slot_t            ex_q, mem_q, wb_q, ex_d;
    logic             load_use_c;

    // A slot can supply a source operand only if it really writes a nonzero register.
    function automatic logic fwd_match(input slot_t s, input logic [REG_AW-1:0] src);
        return s.regwrite && (s.rd != '0) && (s.rd == src);
    endfunction

    // Shadow pipeline slots and FSM state.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ex_q    <= '0;
            mem_q   <= '0;
            wb_q    <= '0;
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            ex_q    <= ex_d;
            mem_q   <= ex_q;
            wb_q    <= mem_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Operand mux selects; the newer producer (EX/MEM) wins a double match.
    always_comb begin
        forward_a_o = SEL_IDEX;
        forward_b_o = SEL_IDEX;
        if (rst_i) begin
            if (fwd_match(mem_q, ex_q.rs))      forward_a_o = SEL_EXMEM;
            else if (fwd_match(wb_q, ex_q.rs))  forward_a_o = SEL_MEMWB;
            if (fwd_match(mem_q, ex_q.rt))      forward_b_o = SEL_EXMEM;
            else if (fwd_match(wb_q, ex_q.rt))  forward_b_o = SEL_MEMWB;
        end
    end

    // Load in EX whose destination is read by the instruction sitting in ID.
    always_comb begin
        load_use_c = ex_q.memread && (ex_q.rd != '0) && id_valid_i &&
                     ((ex_q.rd == id_rs_i) || (id_uses_rt_i && (ex_q.rd == id_rt_i)));
    end

    // Next-state and pipeline control; branch beats load-use, reset forces idle controls.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pc_write_o   = 1'b1;
        ifid_write_o = 1'b1;
        bubble_o     = 1'b0;
        flush_o      = 1'b0;
        case (state_q)
            RUN, STALL: begin
                if (branch_taken_i) begin
                    flush_o  = 1'b1;
                    bubble_o = 1'b1;
                    cnt_d    = FLUSH_LOAD;
                    state_d  = FLUSH_MULTI ? FLUSH : RUN;
                end else if ((state_q == RUN) && load_use_c) begin
                    pc_write_o   = 1'b0;
                    ifid_write_o = 1'b0;
                    bubble_o     = 1'b1;
                    state_d      = STALL;
                end else begin
                    state_d = RUN;
                end
            end
            FLUSH: begin
                if (cnt_q != '0) begin
                    flush_o  = 1'b1;
                    bubble_o = 1'b1;
                    cnt_d    = cnt_q - CNT_W'(1);
                    state_d  = (cnt_q == CNT_W'(1)) ? RUN : FLUSH;
                end else begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = RUN;
                cnt_d   = '0;
            end
        endcase
        if (!rst_i) begin
            pc_write_o   = 1'b1;
            ifid_write_o = 1'b1;
            bubble_o     = 1'b0;
            flush_o      = 1'b0;
        end
    end

    // EX slot capture: the ID instruction when it advances, otherwise a bubble.
    always_comb begin
        ex_d = '0;
        if (!bubble_o) begin
            ex_d.rs       = id_rs_i;
            ex_d.rt       = id_rt_i;
            ex_d.rd       = id_rd_i;
            ex_d.regwrite = id_regwrite_i & id_valid_i;
            ex_d.memread  = id_memread_i & id_valid_i;
        end
    end

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed-vector bench: the driver queues the expected controls per cycle,
// the monitor compares them against the DUT on the falling edge.
module tb_fwd_hazard_ctrl;

    localparam int unsigned AW = 5;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          id_valid_i;
    logic [AW-1:0] id_rs_i, id_rt_i, id_rd_i;
    logic          id_uses_rt_i, id_regwrite_i, id_memread_i, branch_taken_i;
    logic [1:0]    forward_a_o, forward_b_o;
    logic          pc_write_o, ifid_write_o, bubble_o, flush_o;

    // pc_write, ifid_write, bubble, flush
    localparam logic [3:0] NRM = 4'b1100;
    localparam logic [3:0] STL = 4'b0010;
    localparam logic [3:0] FLS = 4'b1111;

    logic [7:0] exp_q[$];
    string      name_q[$];
    int         checks   = 0;
    int         failures = 0;

    fwd_hazard_ctrl #(.REG_AW(AW), .FLUSH_CYCLES(2)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .id_valid_i    (id_valid_i),
        .id_rs_i       (id_rs_i),
        .id_rt_i       (id_rt_i),
        .id_uses_rt_i  (id_uses_rt_i),
        .id_rd_i       (id_rd_i),
        .id_regwrite_i (id_regwrite_i),
        .id_memread_i  (id_memread_i),
        .branch_taken_i(branch_taken_i),
        .forward_a_o   (forward_a_o),
        .forward_b_o   (forward_b_o),
        .pc_write_o    (pc_write_o),
        .ifid_write_o  (ifid_write_o),
        .bubble_o      (bubble_o),
        .flush_o       (flush_o)
    );

    always #5 clk_i = ~clk_i;

    // One cycle of stimulus plus the controls expected during that cycle.
    task automatic step(input string nm, input bit rst, input bit v,
                        input int rs, input int rt, input bit urt, input int rd,
                        input bit rw, input bit mr, input bit br,
                        input logic [1:0] fa, input logic [1:0] fb, input logic [3:0] ctl);
        @(posedge clk_i);
        #1;
        rst_i          = rst;
        id_valid_i     = v;
        id_rs_i        = AW'(rs);
        id_rt_i        = AW'(rt);
        id_uses_rt_i   = urt;
        id_rd_i        = AW'(rd);
        id_regwrite_i  = rw;
        id_memread_i   = mr;
        branch_taken_i = br;
        exp_q.push_back({fa, fb, ctl});
        name_q.push_back(nm);
    endtask

    task automatic nop(input string nm, input logic [1:0] fa, input logic [1:0] fb,
                       input logic [3:0] ctl);
        step(nm, 1'b1, 1'b0, 0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0, fa, fb, ctl);
    endtask

    // Monitor: compare DUT controls against the oldest queued expectation.
    always @(negedge clk_i) begin
        if (exp_q.size() > 0) begin
            logic [7:0] e, a;
            string      n;
            e = exp_q.pop_front();
            n = name_q.pop_front();
            a = {forward_a_o, forward_b_o, pc_write_o, ifid_write_o, bubble_o, flush_o};
            checks++;
            if (a !== e) begin
                failures++;
                $display("FAIL %s: got fa=%b fb=%b pcw=%b ifw=%b bub=%b fl=%b, expected fa=%b fb=%b pcw=%b ifw=%b bub=%b fl=%b",
                         n, a[7:6], a[5:4], a[3], a[2], a[1], a[0],
                         e[7:6], e[5:4], e[3], e[2], e[1], e[0]);
            end
        end
    end

    initial begin
        rst_i = 1'b0; id_valid_i = 1'b0; id_rs_i = '0; id_rt_i = '0; id_rd_i = '0;
        id_uses_rt_i = 1'b0; id_regwrite_i = 1'b0; id_memread_i = 1'b0; branch_taken_i = 1'b0;

        // Reset holds idle controls even with a branch strobe present.
        step("reset_idle",   1'b0, 1'b0, 0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, NRM);
        step("reset_branch", 1'b0, 1'b0, 0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, NRM);

        // Back-to-back ALU: add r3,r1,r2 ; sub r5,r3,r4
        step("b2b_add",  1'b1, 1'b1, 1, 2, 1'b1, 3, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, NRM);
        step("b2b_sub",  1'b1, 1'b1, 3, 4, 1'b1, 5, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, NRM);
        nop("b2b_fwd_ex",    2'b10, 2'b00, NRM);
        nop("b2b_after",     2'b00, 2'b00, NRM);

        // Distance 2: add r3 ; nop ; or r6,r3,r3
        step("d2_add",   1'b1, 1'b1, 1, 2, 1'b1, 3, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, NRM);
        nop("d2_nop",        2'b00, 2'b00, NRM);
        step("d2_or",    1'b1, 1'b1, 3, 3, 1'b1, 6, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, NRM);
        nop("d2_fwd_wb",     2'b01, 2'b01, NRM);
        nop("d2_after",      2'b00, 2'b00, NRM);

        // Double producer: add r2 ; add r2 ; and r7,r2,r1
        step("dbl_add1", 1'b1, 1'b1, 1, 1, 1'b1, 2, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, NRM);
        step("dbl_add2", 1'b1, 1'b1, 3, 3, 1'b1, 2, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, NRM);
        step("dbl_and",  1'b1, 1'b1, 2, 1, 1'b1, 7, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, NRM);
        nop("dbl_newest",    2'b10, 2'b00, NRM);

        // Writes to r0 never forward: add r0,r1,r1 ; sub r8,r0,r0
        step("r0_add",   1'b1, 1'b1, 1, 1, 1'b1, 0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, NRM);
        step("r0_sub",   1'b1, 1'b1, 0, 0, 1'b1, 8, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, NRM);
        nop("r0_exmem",      2'b00, 2'b00, NRM);
        nop("r0_memwb",      2'b00, 2'b00, NRM);

        // Load-use: lw r4 ; add r5,r4,r1
        step("lu_lw",    1'b1, 1'b1, 1, 0, 1'b0, 4, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, NRM);
        step("lu_stall", 1'b1, 1'b1, 4, 1, 1'b1, 5, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, STL);
        step("lu_retry", 1'b1, 1'b1, 4, 1, 1'b1, 5, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, NRM);
        nop("lu_fwd_wb",     2'b01, 2'b00, NRM);
        nop("lu_after",      2'b00, 2'b00, NRM);

        // Branch beats load-use; two flush cycles; branch ignored inside FLUSH.
        step("br_lw",    1'b1, 1'b1, 1, 0, 1'b0, 4, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, NRM);
        step("br_take",  1'b1, 1'b1, 4, 1, 1'b1, 5, 1'b1, 1'b0, 1'b1, 2'b00, 2'b00, FLS);
        step("br_flush2",1'b1, 1'b0, 0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, FLS);
        step("br_done",  1'b1, 1'b1, 1, 2, 1'b1, 3, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, NRM);

        // Reset in the middle of a flush aborts it.
        step("rf_take",  1'b1, 1'b1, 3, 3, 1'b1, 9, 1'b1, 1'b0, 1'b1, 2'b00, 2'b00, FLS);
        step("rf_rst1",  1'b0, 1'b0, 0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, NRM);
        step("rf_rst2",  1'b0, 1'b1, 3, 3, 1'b1, 9, 1'b1, 1'b1, 1'b1, 2'b00, 2'b00, NRM);
        nop("rf_release",    2'b00, 2'b00, NRM);

        // rt only matters for the stall when the instruction reads it; B forwarding.
        step("rt_lw",    1'b1, 1'b1, 1, 0, 1'b0, 4, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, NRM);
        step("rt_nouse", 1'b1, 1'b1, 1, 4, 1'b0, 6, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, NRM);
        nop("rt_fwd_b",      2'b00, 2'b10, NRM);
        step("rt_lw2",   1'b1, 1'b1, 1, 0, 1'b0, 4, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, NRM);
        step("rt_stall", 1'b1, 1'b1, 1, 4, 1'b1, 6, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, STL);
        step("rt_retry", 1'b1, 1'b1, 1, 4, 1'b1, 6, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, NRM);
        nop("rt_fwd_wb",     2'b00, 2'b01, NRM);

        // An invalid ID slot must not be captured as a writer.
        step("iv_ghost", 1'b1, 1'b0, 0, 0, 1'b0, 9, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, NRM);
        step("iv_use",   1'b1, 1'b1, 9, 0, 1'b0, 10, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, NRM);
        nop("iv_nofwd",      2'b00, 2'b00, NRM);

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk_i);
        if (exp_q.size() > 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
